// File: rtl/pcs_tx_pkg.sv
// ---------------------------------------------------------------------------
// pcs_tx_pkg
// Shared types and constants for the PCS transmit sequencer.
//   state_t          : sequencer FSM states
//   SEND_Z / SEND_N  : encoder transmit-mode encodings
//   IFG_MIN_DEFAULT  : default inter-frame gap / link-up warm-up in cycles
// ---------------------------------------------------------------------------
package pcs_tx_pkg;

   typedef enum logic [1:0] {
      ST_ZERO = 2'd0,   // link down, encoder sends zeros
      ST_IDLE = 2'd1,   // link up, counting inter-frame gap
      ST_DATA = 2'd2,   // forwarding frame bytes
      ST_DROP = 2'd3    // discarding rest of an underrun frame
   } state_t;

   localparam logic SEND_Z = 1'b0;
   localparam logic SEND_N = 1'b1;

   localparam int IFG_MIN_DEFAULT = 12;

endpackage : pcs_tx_pkg

// File: rtl/pcs_tx_gap_counter.sv
// ---------------------------------------------------------------------------
// pcs_tx_gap_counter
// Counts idle cycles between frames and saturates at MAX.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear        : force count to 0 (has priority over count)
//   count        : advance by one when below MAX
//   gap_cnt      : current count
//   done         : gap_cnt has reached MAX
// ---------------------------------------------------------------------------
module pcs_tx_gap_counter #(
   parameter int MAX = 12
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       clear,
   input  logic       count,
   output logic [7:0] gap_cnt,
   output logic       done
);

   localparam logic [7:0] MAX_L = 8'(MAX);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clock) begin
      if (reset || clear) begin
         gap_cnt <= 8'd0;
      end else if (count && (gap_cnt != MAX_L)) begin
         gap_cnt <= gap_cnt + 8'd1;
      end
   end

   assign done = (gap_cnt == MAX_L);

endmodule : pcs_tx_gap_counter

// File: rtl/pcs_tx_sequencer.sv
// ---------------------------------------------------------------------------
// pcs_tx_sequencer
// Sequences MAC-side bytes into the PCS encoder: enforces link-up warm-up and
// a minimum inter-frame gap, flags underruns, and counts good/errored frames.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   link_up               : PMA link established
//   loc_rcvr_status       : local receiver OK
//   s_valid/s_data/s_last/s_error/s_ready : MAC byte stream (valid/ready)
//   enc_tx_enable/error/data : registered byte lane to the encoder
//   enc_n, enc_n0         : free-running symbol counter, frame-start index
//   enc_tx_mode           : SEND_Z when link down, SEND_N otherwise
//   enc_loc_rcvr_status   : registered loc_rcvr_status
//   frames_sent           : good frames (wraps)
//   err_count             : errored frames (saturates at 255)
// ---------------------------------------------------------------------------
module pcs_tx_sequencer
   import pcs_tx_pkg::*;
#(
   parameter int IFG_MIN = IFG_MIN_DEFAULT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        link_up,
   input  logic        loc_rcvr_status,
   input  logic        s_valid,
   input  logic [7:0]  s_data,
   input  logic        s_last,
   input  logic        s_error,
   output logic        s_ready,
   output logic        enc_tx_enable,
   output logic        enc_tx_error,
   output logic [7:0]  enc_tx_data,
   output logic [31:0] enc_n,
   output logic [31:0] enc_n0,
   output logic        enc_tx_mode,
   output logic        enc_loc_rcvr_status,
   output logic [15:0] frames_sent,
   output logic [7:0]  err_count
);

   state_t      state, state_nxt;
   logic        gap_clear, gap_count, gap_done;
   logic [7:0]  gap_cnt;
   logic        xfer;
   logic        tx_en_nxt, tx_err_nxt;
   logic [7:0]  tx_data_nxt;
   logic        capture_n0;
   logic        frame_err, frame_err_nxt;   // errored byte seen in this frame
   logic        frame_good, frame_bad;

   pcs_tx_gap_counter #(.MAX(IFG_MIN)) u_gap (
      .clock   (clock),
      .reset   (reset),
      .clear   (gap_clear),
      .count   (gap_count),
      .gap_cnt (gap_cnt),
      .done    (gap_done)
   );

   assign xfer = s_valid & s_ready;

   // NOTE: every signal written here gets a default first so no path through
   // the case/if tree leaves one unassigned (which would infer a latch).
   always_comb begin
      state_nxt     = state;
      s_ready       = 1'b0;
      gap_clear     = 1'b0;
      gap_count     = 1'b0;
      tx_en_nxt     = 1'b0;
      tx_err_nxt    = 1'b0;
      tx_data_nxt   = 8'h00;
      capture_n0    = 1'b0;
      frame_err_nxt = frame_err;
      frame_good    = 1'b0;
      frame_bad     = 1'b0;

      // s_ready depends only on state and the gap counter.
      unique case (state)
         ST_ZERO: s_ready = 1'b0;
         ST_IDLE: s_ready = gap_done;
         ST_DATA: s_ready = 1'b1;
         ST_DROP: s_ready = 1'b1;
         default: s_ready = 1'b0;
      endcase

      if (!link_up) begin
         // Link loss overrides everything; any handshake this cycle is ignored
         // and a frame in flight is counted as errored.
         state_nxt = ST_ZERO;
         frame_bad = (state == ST_DATA) || (state == ST_DROP);
      end else begin
         unique case (state)
            ST_ZERO: begin
               state_nxt = ST_IDLE;
               gap_clear = 1'b1;
            end
            ST_IDLE: begin
               gap_count = 1'b1;
               if (xfer) begin
                  tx_en_nxt     = 1'b1;
                  tx_err_nxt    = s_error;
                  tx_data_nxt   = s_data;
                  capture_n0    = 1'b1;
                  frame_err_nxt = s_error;
                  if (s_last) begin
                     gap_clear  = 1'b1;
                     frame_good = !s_error;
                     frame_bad  = s_error;
                  end else begin
                     state_nxt = ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (xfer) begin
                  tx_en_nxt     = 1'b1;
                  tx_err_nxt    = s_error;
                  tx_data_nxt   = s_data;
                  frame_err_nxt = frame_err | s_error;
                  if (s_last) begin
                     state_nxt  = ST_IDLE;
                     gap_clear  = 1'b1;
                     frame_good = !(frame_err | s_error);
                     frame_bad  = frame_err | s_error;
                  end
               end else begin
                  // Underrun: poison the current symbol, then discard the rest.
                  tx_en_nxt  = 1'b1;
                  tx_err_nxt = 1'b1;
                  state_nxt  = ST_DROP;
               end
            end
            ST_DROP: begin
               if (xfer && s_last) begin
                  state_nxt = ST_IDLE;
                  gap_clear = 1'b1;
                  frame_bad = 1'b1;
               end
            end
            default: state_nxt = ST_ZERO;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state               <= ST_ZERO;
         enc_n               <= 32'd0;
         enc_n0              <= 32'd0;
         enc_tx_enable       <= 1'b0;
         enc_tx_error        <= 1'b0;
         enc_tx_data         <= 8'h00;
         enc_tx_mode         <= SEND_Z;
         enc_loc_rcvr_status <= 1'b0;
         frame_err           <= 1'b0;
         frames_sent         <= 16'd0;
         err_count           <= 8'd0;
      end else begin
         state               <= state_nxt;
         enc_n               <= enc_n + 32'd1;
         enc_tx_enable       <= tx_en_nxt;
         enc_tx_error        <= tx_err_nxt;
         enc_tx_data         <= tx_data_nxt;
         enc_tx_mode         <= (state_nxt == ST_ZERO) ? SEND_Z : SEND_N;
         enc_loc_rcvr_status <= loc_rcvr_status;
         frame_err           <= frame_err_nxt;
         // enc_n0 matches the enc_n value shown alongside the first byte.
         if (capture_n0) begin
            enc_n0 <= enc_n + 32'd1;
         end
         if (frame_good) begin
            frames_sent <= frames_sent + 16'd1;
         end
         if (frame_bad && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
         end
      end
   end

endmodule : pcs_tx_sequencer

// File: tb/tb_pcs_tx_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pcs_tx_sequencer
// Directed bench for pcs_tx_sequencer. Expected encoder bytes are queued as
// bytes are handed over and compared as they appear on the encoder lane.
// ---------------------------------------------------------------------------
module tb_pcs_tx_sequencer;

   logic        clock;
   logic        reset;
   logic        link_up;
   logic        loc_rcvr_status;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_last;
   logic        s_error;
   logic        s_ready;
   logic        enc_tx_enable;
   logic        enc_tx_error;
   logic [7:0]  enc_tx_data;
   logic [31:0] enc_n;
   logic [31:0] enc_n0;
   logic        enc_tx_mode;
   logic        enc_loc_rcvr_status;
   logic [15:0] frames_sent;
   logic [7:0]  err_count;

   pcs_tx_sequencer #(.IFG_MIN(12)) u_dut (
      .clock               (clock),
      .reset               (reset),
      .link_up             (link_up),
      .loc_rcvr_status     (loc_rcvr_status),
      .s_valid             (s_valid),
      .s_data              (s_data),
      .s_last              (s_last),
      .s_error             (s_error),
      .s_ready             (s_ready),
      .enc_tx_enable       (enc_tx_enable),
      .enc_tx_error        (enc_tx_error),
      .enc_tx_data         (enc_tx_data),
      .enc_n               (enc_n),
      .enc_n0              (enc_n0),
      .enc_tx_mode         (enc_tx_mode),
      .enc_loc_rcvr_status (enc_loc_rcvr_status),
      .frames_sent         (frames_sent),
      .err_count           (err_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int          errors = 0;
   int          checks = 0;
   logic [8:0]  exp_q[$];        // {tx_error, tx_data} expected on the lane
   logic [31:0] exp_n = 32'd0;   // model of the symbol counter
   logic [31:0] first_n = 32'd0; // model enc_n at the latest frame start
   int          en_count = 0;
   int          low_run = 0;
   int          last_low_run = 0;
   logic        prev_en = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: advance the counter model, then sample #1 after the edge and
   // score any byte on the encoder lane.
   task automatic step();
      logic [8:0] exp_b;
      @(posedge clock);
      exp_n = reset ? 32'd0 : exp_n + 32'd1;
      #1;
      if (enc_tx_enable === 1'b1) begin
         if (!prev_en) begin
            last_low_run = low_run;
            first_n      = exp_n;
         end
         en_count++;
         if (exp_q.size() == 0) begin
            check("unexpected_tx", 64'(enc_tx_enable), 64'd0);
         end else begin
            exp_b = exp_q.pop_front();
            check("tx_byte", 64'({enc_tx_error, enc_tx_data}), 64'(exp_b));
         end
         low_run = 0;
         prev_en = 1'b1;
      end else begin
         low_run++;
         prev_en = 1'b0;
      end
   endtask

   // Offer one byte, wait (bounded) for s_ready, hand it over.
   task automatic drive_byte(input logic [7:0] d, input logic last, input logic err,
                             input logic shown);
      int w = 0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = last;
      s_error = err;
      while (s_ready !== 1'b1 && w < 100) begin
         step();
         w++;
      end
      check("ready_wait", 64'(s_ready), 64'd1);
      if (shown) exp_q.push_back({err, d});
      step();
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (s_ready !== 1'b1 && n < 100) begin
         step();
         n++;
      end
   endtask

   task automatic idle(input int cycles);
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_error = 1'b0;
      for (int i = 0; i < cycles; i++) step();
   endtask

   initial begin
      int n;
      reset = 1'b1; link_up = 1'b0; loc_rcvr_status = 1'b1;
      s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; s_error = 1'b0;

      // Reset state
      for (int i = 0; i < 4; i++) step();
      check("rst_s_ready", 64'(s_ready), 64'd0);
      check("rst_enable", 64'(enc_tx_enable), 64'd0);
      check("rst_enc_n", 64'(enc_n), 64'd0);
      check("rst_enc_n0", 64'(enc_n0), 64'd0);
      check("rst_mode", 64'(enc_tx_mode), 64'd0);
      check("rst_counts", 64'({frames_sent, err_count}), 64'd0);

      // Link-up warm-up
      reset = 1'b0; link_up = 1'b1;
      step();
      check("idle_mode", 64'(enc_tx_mode), 64'd1);
      check("idle_enc_n", 64'(enc_n), 64'(exp_n));
      wait_ready(n);
      check("warmup_cycles", 64'(n), 64'd12);
      check("warmup_enc_n", 64'(enc_n), 64'd13);
      check("loc_rcvr_copy", 64'(enc_loc_rcvr_status), 64'd1);

      // 62-byte frame, continuous valid
      en_count = 0;
      for (int i = 0; i < 62; i++) begin
         logic [7:0] b;
         b = (i == 0) ? 8'h55 : (i == 1) ? 8'hD5 : 8'(i - 1);
         drive_byte(b, i == 61, 1'b0, 1'b1);
      end
      idle(3);
      check("frameA_enable_cycles", 64'(en_count), 64'd62);
      check("frameA_enc_n0", 64'(enc_n0), 64'(first_n));
      check("frameA_drained", 64'(exp_q.size()), 64'd0);
      check("frameA_frames_sent", 64'(frames_sent), 64'd1);
      check("frameA_err_count", 64'(err_count), 64'd0);

      // Back-to-back frames with valid held high across the gap
      for (int f = 0; f < 2; f++)
         for (int i = 0; i < 8; i++)
            drive_byte(8'(8'h80 + 8'(f * 16 + i)), i == 7, 1'b0, 1'b1);
      check("b2b_gap", 64'(last_low_run), 64'd12);
      idle(1);
      check("b2b_frames_sent", 64'(frames_sent), 64'd3);

      // One-byte frame
      drive_byte(8'hA5, 1'b1, 1'b0, 1'b1);
      idle(1);
      check("one_byte_frames_sent", 64'(frames_sent), 64'd4);

      // Underrun after byte 10 of 20, remainder drained in DROP
      for (int i = 0; i < 10; i++) drive_byte(8'(8'h10 + 8'(i)), 1'b0, 1'b0, 1'b1);
      s_valid = 1'b0;
      exp_q.push_back(9'h100);
      step();
      check("underrun_drop_ready", 64'(s_ready), 64'd1);
      for (int i = 10; i < 20; i++) drive_byte(8'(8'h10 + 8'(i)), i == 19, 1'b0, 1'b0);
      idle(1);
      check("underrun_drained", 64'(exp_q.size()), 64'd0);
      check("underrun_err_count", 64'(err_count), 64'd1);
      check("underrun_frames_sent", 64'(frames_sent), 64'd4);

      // Frame carrying an errored byte
      for (int i = 0; i < 4; i++) drive_byte(8'(8'hC0 + 8'(i)), i == 3, i == 1, 1'b1);
      idle(1);
      check("serr_err_count", 64'(err_count), 64'd2);
      check("serr_frames_sent", 64'(frames_sent), 64'd4);

      // Link loss mid-frame, then relink warm-up
      for (int i = 0; i < 5; i++) drive_byte(8'(8'hE0 + 8'(i)), 1'b0, 1'b0, 1'b1);
      s_valid = 1'b0;
      link_up = 1'b0;
      step();
      check("linkdown_mode", 64'(enc_tx_mode), 64'd0);
      check("linkdown_enable", 64'(enc_tx_enable), 64'd0);
      check("linkdown_error", 64'(enc_tx_error), 64'd0);
      check("linkdown_s_ready", 64'(s_ready), 64'd0);
      check("linkdown_err_count", 64'(err_count), 64'd3);
      idle(3);
      link_up = 1'b1;
      step();
      wait_ready(n);
      check("relink_warmup", 64'(n), 64'd12);

      // Symbol counter wrap during a frame
      force u_dut.enc_n = 32'hFFFF_FFFA;
      exp_n = 32'hFFFF_FFFA;
      #1;
      release u_dut.enc_n;
      for (int i = 0; i < 10; i++) drive_byte(8'(8'h30 + 8'(i)), i == 9, 1'b0, 1'b1);
      idle(4);
      check("wrap_enc_n0", 64'(enc_n0), 64'hFFFF_FFFB);
      check("wrap_enc_n", 64'(enc_n), 64'(exp_n));
      check("wrap_enc_n_small", 64'(enc_n < 32'd32), 64'd1);
      check("wrap_frames_sent", 64'(frames_sent), 64'd5);

      // Registered receiver status
      loc_rcvr_status = 1'b0;
      step();
      check("loc_rcvr_low", 64'(enc_loc_rcvr_status), 64'd0);
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_pcs_tx_sequencer

// File: doc/pcs_tx_sequencer.md
PCS_TX_SEQUENCER -- requirements
Module: pcs_tx_sequencer

Interface
REQ-001 SHALL have parameter IFG_MIN, default 12, meaning the minimum number of cycles with enc_tx_enable low between frames (also the idle warm-up after link-up); legal range 3..255.
REQ-002 SHALL have ports: clock  in  1  single clock; all logic on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 link_up  in  1  PMA link established.
REQ-005 loc_rcvr_status  in  1  local receiver OK.
REQ-006 s_valid  in  1  MAC-side byte valid.
REQ-007 s_data  in  8  MAC-side byte.
REQ-008 s_last  in  1  final byte of frame.
REQ-009 s_error  in  1  MAC-flagged errored byte.
REQ-010 s_ready  out  1  sequencer accepts byte (transfer = s_valid & s_ready).
REQ-011 enc_tx_enable, enc_tx_error  out  1 each  to Encoder.
REQ-012 enc_tx_data  out  8  to Encoder.
REQ-013 enc_n, enc_n0  out  32 each  symbol counter and SSD start index to Encoder.
REQ-014 enc_tx_mode  out  1  0=SEND_Z, 1=SEND_N.
REQ-015 enc_loc_rcvr_status  out  1  registered copy of loc_rcvr_status.
REQ-016 frames_sent  out  16  good frames, wraps; err_count  out  8  errored frames, saturates at 255.

Function
REQ-017 SHALL implement FSM states ZERO, IDLE, DATA, DROP; all enc_* outputs registered (one-cycle latency from accepted byte to enc_tx_data).
REQ-018 enc_n SHALL increment by 1 every cycle, wrapping 0xFFFFFFFF->0, independent of state.
REQ-019 ZERO: enc_tx_mode=0, enc_tx_enable=0, s_ready=0; link_up=1 -> IDLE with gap_cnt cleared to 0.
REQ-020 IDLE: enc_tx_mode=1, enc_tx_enable=0; gap_cnt increments, saturating at IFG_MIN; s_ready=1 only when gap_cnt==IFG_MIN.
REQ-021 IDLE transfer: next cycle enc_tx_enable=1, enc_tx_data=s_data, enc_tx_error=s_error, enc_n0 captures the enc_n value presented in that same cycle; -> DATA, or stays IDLE (gap_cnt=0) if s_last (one-byte frame).
REQ-022 DATA: s_ready=1; each transfer drives the byte next cycle with enc_tx_enable=1; transfer with s_last -> IDLE, gap_cnt=0, enc_tx_enable falls the cycle after the last byte.
REQ-023 DATA with s_valid=0 (underrun): next cycle enc_tx_enable=1, enc_tx_error=1, enc_tx_data=0x00; -> DROP.
REQ-024 DROP: enc_tx_enable=0, s_ready=1, bytes discarded; transfer with s_last -> IDLE, gap_cnt=0.
REQ-025 frames_sent SHALL increment on a frame ending via s_last in DATA/IDLE with no s_error byte in it; err_count increments once per frame containing any s_error byte or an underrun.
REQ-026 link_up=0 in any state SHALL force ZERO next cycle: enc_tx_enable=0, enc_tx_error=0, s_ready=0; an in-progress frame counts as errored; bytes still pending upstream are not consumed.
REQ-027 enc_n0 SHALL hold its value between frame starts.
REQ-028 s_ready SHALL be combinational from state and gap_cnt only, never from s_valid.

Reset
REQ-029 On reset: state=ZERO, enc_n=0, enc_n0=0, gap_cnt=0, frames_sent=0, err_count=0, all other enc_* outputs 0, s_ready=0; reset mid-frame abandons the frame without counting it.

Structure
REQ-030 Package pcs_tx_pkg SHALL hold the state enum, SEND_Z/SEND_N constants and IFG_MIN default.
REQ-031 Gap counting SHALL live in sub-module pcs_tx_gap_counter (clear, count, saturate, done flag).

Verification
REQ-032 Reset 4 cycles, link_up=1 -> s_ready rises exactly 12 cycles after IDLE entry; enc_n==cycles since reset release.
REQ-033 Frame 0x55,0xD5,0x01..0x3C with s_valid continuous -> enc_tx_enable high for exactly 62 cycles, bytes in order, enc_n0 = enc_n at first byte, frames_sent=1.
REQ-034 Back-to-back frames held ready -> enc_tx_enable low exactly 12 cycles between them.
REQ-035 s_valid dropped after byte 10 of 20 -> byte 11 slot: tx_enable=1, tx_error=1, data=0x00; remaining bytes drained in DROP; err_count=1, frames_sent unchanged.
REQ-036 link_up deasserted mid-frame -> next cycle enc_tx_mode=0, enc_tx_enable=0; err_count+1; relink gives 12-cycle warm-up.
REQ-037 Preload enc_n near 0xFFFFFFFF via forced start and run a frame across the wrap -> enc_n rolls to 0, enc_n0 unaffected.
